spatz_retire_unit: RTL and testbench

- Response side of the Spatz request path: records every issued spatz_req_t by instruction ID and collects completions from the VFU (vfu_rsp_t: id, wb, result), LSU and SLD.
- Retires instructions strictly in issue order.
- Returns scalar results (rd writeback) to the scalar core over a valid/ready handshake.
- Sits between the Spatz controller's issue stage and the core response interface.

---
 rtl/spatz_retire_unit.sv | 152 +++++++++++++++
 tb/tb_spatz_retire_unit.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spatz_retire_unit.sv
// Response side of the Spatz request path: tracks issued instructions by ID,
// collects VFU/LSU/SLD completions and retires strictly in issue order.
module spatz_retire_unit #(
    parameter int NrOutstanding = 8,
    parameter int ELEN          = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            issue_valid_i,
    output logic            issue_ready_o,
    input  logic [3:0]      issue_id_i,
    input  logic            issue_use_rd_i,
    input  logic [4:0]      issue_rd_i,
    input  logic            vfu_rsp_valid_i,
    input  logic [ELEN+4:0] vfu_rsp_i,
    input  logic            lsu_done_valid_i,
    input  logic [3:0]      lsu_done_id_i,
    input  logic            sld_done_valid_i,
    input  logic [3:0]      sld_done_id_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [3:0]      rsp_id_o,
    output logic [4:0]      rsp_rd_o,
    output logic            rsp_write_o,
    output logic [ELEN-1:0] rsp_data_o,
    output logic            retire_valid_o,
    output logic [3:0]      retire_id_o,
    output logic [4:0]      outstanding_o,
    output logic            empty_o,
    output logic            cmpl_err_o
);

    localparam int NrIds = 16;
    localparam int PtrW  = (NrOutstanding > 1) ? $clog2(NrOutstanding) : 1;

    typedef struct packed {
        logic [3:0]      id;
        logic            wb;
        logic [ELEN-1:0] result;
    } vfu_rsp_t;

    vfu_rsp_t vfu_rsp;
    assign vfu_rsp = vfu_rsp_i;

    // Per-ID scoreboard
    logic [NrIds-1:0]           busy_q, done_q, use_rd_q, wb_q;
    logic [NrIds-1:0][4:0]      rd_q;
    logic [NrIds-1:0][ELEN-1:0] data_q;

    // Issue-order FIFO of IDs
    logic [NrOutstanding-1:0][3:0] fifo_q;
    logic [PtrW-1:0]               rd_ptr_q, wr_ptr_q;
    logic [4:0]                    count_q;

    logic       cmpl_err_q;
    logic       issue_fire, push, pop;
    logic       vfu_ok, lsu_ok, sld_ok, err_d;
    logic [3:0] head;
    logic       head_done;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(NrOutstanding - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign issue_ready_o = !busy_q[issue_id_i] && (count_q < 5'(NrOutstanding));
    assign issue_fire    = issue_valid_i && issue_ready_o;
    assign push          = issue_fire;

    // Lower-priority ports lose to a higher-priority port presenting the same ID.
    assign vfu_ok = vfu_rsp_valid_i && busy_q[vfu_rsp.id] && !done_q[vfu_rsp.id]
                 && !(issue_fire && issue_id_i == vfu_rsp.id)
                 && !(vfu_rsp.wb && !use_rd_q[vfu_rsp.id]);
    assign lsu_ok = lsu_done_valid_i && busy_q[lsu_done_id_i] && !done_q[lsu_done_id_i]
                 && !(issue_fire && issue_id_i == lsu_done_id_i)
                 && !(vfu_rsp_valid_i && vfu_rsp.id == lsu_done_id_i);
    assign sld_ok = sld_done_valid_i && busy_q[sld_done_id_i] && !done_q[sld_done_id_i]
                 && !(issue_fire && issue_id_i == sld_done_id_i)
                 && !(vfu_rsp_valid_i && vfu_rsp.id == sld_done_id_i)
                 && !(lsu_done_valid_i && lsu_done_id_i == sld_done_id_i);
    assign err_d  = (vfu_rsp_valid_i && !vfu_ok) || (lsu_done_valid_i && !lsu_ok)
                 || (sld_done_valid_i && !sld_ok);

    assign head      = fifo_q[rd_ptr_q];
    assign head_done = (count_q != 5'd0) && done_q[head];
    assign rsp_valid_o = head_done && use_rd_q[head];
    assign pop         = head_done && (!use_rd_q[head] || rsp_ready_i);

    assign rsp_id_o       = rsp_valid_o ? head : 4'd0;
    assign rsp_rd_o       = rsp_valid_o ? rd_q[head] : 5'd0;
    assign rsp_write_o    = rsp_valid_o && wb_q[head];
    assign rsp_data_o     = rsp_valid_o ? data_q[head] : '0;
    assign retire_valid_o = pop;
    assign retire_id_o    = pop ? head : 4'd0;
    assign outstanding_o  = count_q;
    assign empty_o        = (count_q == 5'd0);
    assign cmpl_err_o     = cmpl_err_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_q   <= '0;
            done_q   <= '0;
            use_rd_q <= '0;
            wb_q     <= '0;
            rd_q     <= '0;
            data_q   <= '0;
        end else begin
            // A legal completion never targets the head being popped or the
            // ID being issued, so these updates never collide on one entry.
            for (int i = 0; i < NrIds; i++) begin
                if (pop && head == 4'(i)) begin
                    busy_q[i] <= 1'b0;
                    done_q[i] <= 1'b0;
                end
                if (issue_fire && issue_id_i == 4'(i)) begin
                    busy_q[i]   <= 1'b1;
                    done_q[i]   <= 1'b0;
                    use_rd_q[i] <= issue_use_rd_i;
                    rd_q[i]     <= issue_rd_i;
                end
                if (vfu_ok && vfu_rsp.id == 4'(i)) begin
                    done_q[i] <= 1'b1;
                    wb_q[i]   <= vfu_rsp.wb;
                    data_q[i] <= vfu_rsp.wb ? vfu_rsp.result : '0;
                end
                if ((lsu_ok && lsu_done_id_i == 4'(i)) || (sld_ok && sld_done_id_i == 4'(i))) begin
                    done_q[i] <= 1'b1;
                    wb_q[i]   <= 1'b0;
                    data_q[i] <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fifo_q     <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            cmpl_err_q <= 1'b0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= issue_id_i;
                wr_ptr_q         <= ptr_inc(wr_ptr_q);
            end
            if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
            count_q    <= count_q + {4'd0, push} - {4'd0, pop};
            cmpl_err_q <= err_d;
        end
    end

endmodule

// File: tb/tb_spatz_retire_unit.sv
// Scoreboard bench for spatz_retire_unit: issue order and per-ID result model
// predict every retire and scalar response; directed checks cover errors/reset.
module tb_spatz_retire_unit;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        issue_valid_i = 1'b0;
    logic        issue_ready_o;
    logic [3:0]  issue_id_i = '0;
    logic        issue_use_rd_i = 1'b0;
    logic [4:0]  issue_rd_i = '0;
    logic        vfu_rsp_valid_i = 1'b0;
    logic [36:0] vfu_rsp_i = '0;
    logic        lsu_done_valid_i = 1'b0;
    logic [3:0]  lsu_done_id_i = '0;
    logic        sld_done_valid_i = 1'b0;
    logic [3:0]  sld_done_id_i = '0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b1;
    logic [3:0]  rsp_id_o;
    logic [4:0]  rsp_rd_o;
    logic        rsp_write_o;
    logic [31:0] rsp_data_o;
    logic        retire_valid_o;
    logic [3:0]  retire_id_o;
    logic [4:0]  outstanding_o;
    logic        empty_o;
    logic        cmpl_err_o;

    spatz_retire_unit #(.NrOutstanding(8), .ELEN(32)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
        .issue_id_i(issue_id_i), .issue_use_rd_i(issue_use_rd_i), .issue_rd_i(issue_rd_i),
        .vfu_rsp_valid_i(vfu_rsp_valid_i), .vfu_rsp_i(vfu_rsp_i),
        .lsu_done_valid_i(lsu_done_valid_i), .lsu_done_id_i(lsu_done_id_i),
        .sld_done_valid_i(sld_done_valid_i), .sld_done_id_i(sld_done_id_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_id_o(rsp_id_o),
        .rsp_rd_o(rsp_rd_o), .rsp_write_o(rsp_write_o), .rsp_data_o(rsp_data_o),
        .retire_valid_o(retire_valid_o), .retire_id_o(retire_id_o),
        .outstanding_o(outstanding_o), .empty_o(empty_o), .cmpl_err_o(cmpl_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] id;
        logic       use_rd;
        logic [4:0] rd;
    } sb_t;

    sb_t         sb[$];
    logic [31:0] exp_data [16];
    logic        exp_wb [16];
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: every retire must match the oldest issued entry.
    always @(negedge clk) begin
        if (!rst_i && retire_valid_o) begin
            if (sb.size() == 0) begin
                chk("retire_unexpected", 64'(retire_id_o), 64'hFF);
            end else begin
                sb_t e;
                e = sb.pop_front();
                chk("retire_id", 64'(retire_id_o), 64'(e.id));
                if (e.use_rd) begin
                    chk("rsp_handshake", 64'(rsp_valid_o && rsp_ready_i), 64'd1);
                    chk("rsp_id", 64'(rsp_id_o), 64'(e.id));
                    chk("rsp_rd", 64'(rsp_rd_o), 64'(e.rd));
                    chk("rsp_data", 64'(rsp_data_o), 64'(exp_data[e.id]));
                    chk("rsp_write", 64'(rsp_write_o), 64'(exp_wb[e.id]));
                end else begin
                    chk("no_rsp_for_nord", 64'(rsp_valid_o), 64'd0);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] id, input logic use_rd, input logic [4:0] rd);
        bit ok = 1'b0;
        issue_valid_i = 1'b1; issue_id_i = id; issue_use_rd_i = use_rd; issue_rd_i = rd;
        for (int c = 0; c < 30 && !ok; c++) begin
            @(negedge clk);
            if (issue_ready_o) begin
                ok = 1'b1;
                sb.push_back('{id: id, use_rd: use_rd, rd: rd});
            end
            tick();
        end
        issue_valid_i = 1'b0;
        chk("issue_accept", 64'(ok), 64'd1);
    endtask

    task automatic vfu_cmpl(input logic [3:0] id, input logic wb, input logic [31:0] d);
        vfu_rsp_valid_i = 1'b1; vfu_rsp_i = {id, wb, d};
        exp_wb[id] = wb; exp_data[id] = wb ? d : 32'd0;
        tick();
        vfu_rsp_valid_i = 1'b0;
    endtask

    task automatic lsu_cmpl(input logic [3:0] id);
        lsu_done_valid_i = 1'b1; lsu_done_id_i = id;
        exp_wb[id] = 1'b0; exp_data[id] = 32'd0;
        tick();
        lsu_done_valid_i = 1'b0;
    endtask

    task automatic sld_cmpl(input logic [3:0] id);
        sld_done_valid_i = 1'b1; sld_done_id_i = id;
        exp_wb[id] = 1'b0; exp_data[id] = 32'd0;
        tick();
        sld_done_valid_i = 1'b0;
    endtask

    task automatic drain();
        for (int c = 0; c < 100 && !empty_o; c++) tick();
        @(negedge clk);
        chk("drain_empty", 64'(empty_o), 64'd1);
        tick();
    endtask

    initial begin
        // Reset values
        @(negedge clk);
        chk("rst_issue_ready", 64'(issue_ready_o), 64'd1);
        chk("rst_empty", 64'(empty_o), 64'd1);
        chk("rst_outstanding", 64'(outstanding_o), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
        chk("rst_retire", 64'(retire_valid_o), 64'd0);
        chk("rst_err", 64'(cmpl_err_o), 64'd0);
        chk("rst_data", 64'(rsp_data_o), 64'd0);
        tick();
        rst_i = 1'b0;
        tick();

        // Single scalar result round trip
        rsp_ready_i = 1'b0;
        issue(4'd3, 1'b1, 5'd10);
        @(negedge clk);
        chk("t1_pre_valid", 64'(rsp_valid_o), 64'd0);
        tick();
        vfu_cmpl(4'd3, 1'b1, 32'hDEADBEEF);
        @(negedge clk);
        chk("t1_rsp_valid", 64'(rsp_valid_o), 64'd1);
        chk("t1_rsp_rd", 64'(rsp_rd_o), 64'd10);
        chk("t1_rsp_data", 64'(rsp_data_o), 64'hDEADBEEF);
        chk("t1_rsp_write", 64'(rsp_write_o), 64'd1);
        chk("t1_no_err", 64'(cmpl_err_o), 64'd0);
        tick();
        rsp_ready_i = 1'b1;
        @(negedge clk);
        chk("t1_retire", 64'(retire_valid_o), 64'd1);
        tick();
        @(negedge clk);
        chk("t1_empty", 64'(empty_o), 64'd1);
        tick();

        // Out-of-order completion, in-order retire on consecutive cycles
        issue(4'd1, 1'b0, 5'd0);
        issue(4'd2, 1'b0, 5'd0);
        issue(4'd5, 1'b0, 5'd0);
        sld_cmpl(4'd5);
        lsu_cmpl(4'd2);
        @(negedge clk);
        chk("t2_wait_head", 64'(retire_valid_o), 64'd0);
        tick();
        vfu_cmpl(4'd1, 1'b0, 32'h1234);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t2_consecutive", 64'(retire_valid_o), 64'd1);
            tick();
        end
        drain();

        // Fill all entries; 9th must stall until one retires
        for (int k = 0; k < 8; k++) issue(4'(k), 1'b0, 5'd0);
        issue_valid_i = 1'b1; issue_id_i = 4'd8; issue_use_rd_i = 1'b0;
        @(negedge clk);
        chk("t3_full_ready", 64'(issue_ready_o), 64'd0);
        chk("t3_full_count", 64'(outstanding_o), 64'd8);
        tick();
        issue_valid_i = 1'b0;
        lsu_cmpl(4'd0);
        issue(4'd8, 1'b0, 5'd0);
        lsu_cmpl(4'd8);
        for (int k = 7; k >= 1; k--) lsu_cmpl(4'(k));
        drain();

        // Back-pressured scalar head blocks a completed follower
        rsp_ready_i = 1'b0;
        issue(4'd6, 1'b1, 5'd7);
        issue(4'd10, 1'b0, 5'd0);
        lsu_cmpl(4'd10);
        vfu_cmpl(4'd6, 1'b1, 32'h12345678);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t4_hold_valid", 64'(rsp_valid_o), 64'd1);
            chk("t4_hold_data", 64'(rsp_data_o), 64'h12345678);
            chk("t4_hold_rd", 64'(rsp_rd_o), 64'd7);
            chk("t4_no_retire", 64'(retire_valid_o), 64'd0);
            tick();
        end
        rsp_ready_i = 1'b1;
        drain();

        // Same-ID collision and completion of an unissued ID
        rsp_ready_i = 1'b0;
        issue(4'd4, 1'b1, 5'd2);
        vfu_rsp_valid_i = 1'b1; vfu_rsp_i = {4'd4, 1'b1, 32'h0000A5A5};
        lsu_done_valid_i = 1'b1; lsu_done_id_i = 4'd4;
        exp_wb[4] = 1'b1; exp_data[4] = 32'h0000A5A5;
        tick();
        vfu_rsp_valid_i = 1'b0; lsu_done_valid_i = 1'b0;
        @(negedge clk);
        chk("t5_err_pulse", 64'(cmpl_err_o), 64'd1);
        chk("t5_vfu_data", 64'(rsp_data_o), 64'h0000A5A5);
        chk("t5_vfu_write", 64'(rsp_write_o), 64'd1);
        tick();
        @(negedge clk);
        chk("t5_err_single", 64'(cmpl_err_o), 64'd0);
        tick();
        lsu_done_valid_i = 1'b1; lsu_done_id_i = 4'd9;
        tick();
        lsu_done_valid_i = 1'b0;
        @(negedge clk);
        chk("t5_err_unissued", 64'(cmpl_err_o), 64'd1);
        chk("t5_count_same", 64'(outstanding_o), 64'd1);
        chk("t5_head_same", 64'(rsp_data_o), 64'h0000A5A5);
        tick();
        rsp_ready_i = 1'b1;
        drain();

        // Asynchronous reset with work in flight
        rsp_ready_i = 1'b0;
        issue(4'd11, 1'b1, 5'd3);
        issue(4'd12, 1'b0, 5'd0);
        issue(4'd13, 1'b0, 5'd0);
        vfu_cmpl(4'd11, 1'b1, 32'hCAFEF00D);
        @(negedge clk);
        chk("t6_pre_valid", 64'(rsp_valid_o), 64'd1);
        #2 rst_i = 1'b1;
        #1;
        chk("t6_rst_valid", 64'(rsp_valid_o), 64'd0);
        chk("t6_rst_empty", 64'(empty_o), 64'd1);
        chk("t6_rst_count", 64'(outstanding_o), 64'd0);
        chk("t6_rst_ready", 64'(issue_ready_o), 64'd1);
        chk("t6_rst_data", 64'(rsp_data_o), 64'd0);
        sb.delete();
        tick();
        rst_i = 1'b0;
        rsp_ready_i = 1'b1;
        tick();
        lsu_cmpl(4'd12);
        @(negedge clk);
        chk("t6_stale_err", 64'(cmpl_err_o), 64'd1);
        chk("t6_still_empty", 64'(empty_o), 64'd1);
        tick();

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
